sobel_edge_detector: RTL and testbench

- Sits directly downstream of the 3x3 line buffer and consumes its 72-bit window stream and window-valid strobe.
- Computes the Sobel gradient magnitude |Gx|+|Gy| for each window, saturated to 8 bits, through a 3-stage pipeline.
- Tracks window column and row so that windows spanning a line wrap are forced to 0.
- Produces one edge pixel per valid window to the output/display stage.

---
 rtl/img_proc_defs_pkg.sv | 30 +++
 rtl/sobel_abs_sat.sv | 21 ++
 rtl/sobel_edge_detector.sv | 191 +++++++++++++++++++
 tb/tb_sobel_edge_detector.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/img_proc_defs_pkg.sv
// img_proc_defs_pkg: pixel/window definitions shared by the line buffer and
// the window consumers of the image pipeline.
// Window layout: pixel p[r][c] sits at bits [8*(3r+c)+7 : 8*(3r+c)],
// r=0 is the oldest (top) row and c=0 is the oldest (left) column.

`ifndef IMG_PIX_LSB
`define IMG_PIX_LSB(r, c) (8 * (3 * (r) + (c)))
`endif

package img_proc_defs_pkg;

    localparam int PIX_W              = 8;
    localparam int WIN_W              = 9 * PIX_W;
    localparam int LINE_WIDTH_DEFAULT = 640;
    localparam int IMG_HEIGHT_DEFAULT = 480;

    // Extract pixel p[r][c] from a packed 3x3 window.
    function automatic logic [PIX_W-1:0] get_pix(input logic [WIN_W-1:0] win,
                                                 input int r, input int c);
        return win[`IMG_PIX_LSB(r, c) +: PIX_W];
    endfunction

    // 1-2-1 weighted tap sum of three pixels; max 1020, fits in 10 bits.
    function automatic logic [9:0] tap121(input logic [PIX_W-1:0] a,
                                          input logic [PIX_W-1:0] b,
                                          input logic [PIX_W-1:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

endpackage

// File: rtl/sobel_abs_sat.sv
// sobel_abs_sat: combinational |Gx|+|Gy| with saturation to one 8-bit pixel.

module sobel_abs_sat (
    input  logic signed [10:0] gx,
    input  logic signed [10:0] gy,
    output logic [7:0]         mag
);

    logic [10:0] abs_x;
    logic [10:0] abs_y;
    logic [10:0] sum;

    // Magnitudes are at most 1020 each, so the sum (max 2040) fits 11 bits.
    always_comb begin
        abs_x = gx[10] ? $unsigned(-gx) : $unsigned(gx);
        abs_y = gy[10] ? $unsigned(-gy) : $unsigned(gy);
        sum   = abs_x + abs_y;
        mag   = (sum > 11'd255) ? 8'hFF : sum[7:0];
    end

endmodule

// File: rtl/sobel_edge_detector.sv
// sobel_edge_detector: 3-stage Sobel gradient magnitude on a 3x3 window stream.
// Stage 1 registers the 1-2-1 column/row sums and the border flag, stage 2
// registers signed Gx/Gy, stage 3 registers the saturated (or thresholded)
// edge pixel. Latency 3, one window per clock, no backpressure.
// Optional feature macro: SOBEL_THRESH_EN (adds thresh port, binary 0/255 out).

module sobel_edge_detector
    import img_proc_defs_pkg::*;
#(
    parameter int LINE_WIDTH = LINE_WIDTH_DEFAULT,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEFAULT
`ifdef SOBEL_THRESH_EN
    ,
    parameter logic [7:0] THRESH_DEFAULT = 8'd64
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [71:0]  window_in,
    input  logic         window_valid,
    input  logic         frame_start,
`ifdef SOBEL_THRESH_EN
    input  logic [7:0]   thresh,
`endif
    output logic [7:0]   edge_out,
    output logic         edge_valid,
    output logic         frame_done
);

    localparam int COL_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    // Window position counters.
    logic [COL_W-1:0] col_q, col_d, win_col;
    logic [ROW_W-1:0] row_q, row_d, win_row;

    // Stage 1: weighted sums, border flag, frame-done tag, valid.
    logic [9:0] s1_l_q, s1_l_d, s1_r_q, s1_r_d;
    logic [9:0] s1_t_q, s1_t_d, s1_b_q, s1_b_d;
    logic       s1_border_q, s1_border_d;
    logic       s1_fdone_q, s1_fdone_d;
    logic       s1_valid_q, s1_valid_d;

    // Stage 2: signed gradients.
    logic signed [10:0] s2_gx_q, s2_gx_d, s2_gy_q, s2_gy_d;
    logic               s2_border_q, s2_border_d;
    logic               s2_fdone_q, s2_fdone_d;
    logic               s2_valid_q, s2_valid_d;

    // Stage 3: output registers.
    logic [7:0] edge_q, edge_d;
    logic       edge_valid_q, edge_valid_d;
    logic       frame_done_q, frame_done_d;

`ifdef SOBEL_THRESH_EN
    // Threshold travels with its window so a change never retimes older ones.
    logic [7:0] s1_thresh_q, s1_thresh_d;
    logic [7:0] s2_thresh_q, s2_thresh_d;
`endif

    logic [7:0] p00, p01, p02, p10, p12, p20, p21, p22;
    logic [7:0] mag;

    // The centre pixel has zero weight in both Sobel kernels.
    logic [7:0] unused_center;
    assign unused_center = get_pix(window_in, 1, 1);

    // Counter update and stage-1 arithmetic.
    always_comb begin
        // NOTE: every _d gets a value on every path here, so no latch can be inferred.
        p00 = get_pix(window_in, 0, 0);
        p01 = get_pix(window_in, 0, 1);
        p02 = get_pix(window_in, 0, 2);
        p10 = get_pix(window_in, 1, 0);
        p12 = get_pix(window_in, 1, 2);
        p20 = get_pix(window_in, 2, 0);
        p21 = get_pix(window_in, 2, 1);
        p22 = get_pix(window_in, 2, 2);

        // frame_start wins: the coincident window is treated as col 0, row 0.
        win_col = frame_start ? '0 : col_q;
        win_row = frame_start ? '0 : row_q;
        col_d   = win_col;
        row_d   = win_row;
        if (window_valid) begin
            if (win_col == COL_LAST) begin
                col_d = '0;
                row_d = (win_row == ROW_LAST) ? '0 : win_row + 1'b1;
            end else begin
                col_d = win_col + 1'b1;
            end
        end

        s1_l_d      = tap121(p00, p10, p20);
        s1_r_d      = tap121(p02, p12, p22);
        s1_t_d      = tap121(p00, p01, p02);
        s1_b_d      = tap121(p20, p21, p22);
        // The first two windows of a line still hold pixels of the previous line.
        s1_border_d = (win_col < COL_W'(2));
        s1_fdone_d  = window_valid && (win_col == COL_LAST) && (win_row == ROW_LAST);
        s1_valid_d  = window_valid;
`ifdef SOBEL_THRESH_EN
        s1_thresh_d = window_valid ? thresh : s1_thresh_q;
`endif
    end

    // Stage-2 gradients and stage-3 output selection.
    always_comb begin
        s2_gx_d      = $signed({1'b0, s1_r_q}) - $signed({1'b0, s1_l_q});
        s2_gy_d      = $signed({1'b0, s1_b_q}) - $signed({1'b0, s1_t_q});
        s2_border_d  = s1_border_q;
        s2_fdone_d   = s1_fdone_q;
        s2_valid_d   = s1_valid_q;
`ifdef SOBEL_THRESH_EN
        s2_thresh_d  = s1_valid_q ? s1_thresh_q : s2_thresh_q;
        // S >= thr equals min(S,255) >= thr because thr never exceeds 255.
        edge_d       = (mag >= s2_thresh_q) ? 8'hFF : 8'h00;
`else
        edge_d       = mag;
`endif
        if (s2_border_q) begin
            edge_d = 8'h00;
        end
        edge_valid_d = s2_valid_q;
        frame_done_d = s2_fdone_q;
    end

    sobel_abs_sat u_abs_sat (
        .gx  (s2_gx_q),
        .gy  (s2_gy_q),
        .mag (mag)
    );

    // All state: counters, pipeline data, valid and frame-done tags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: data registers are reset too, so nothing stale can appear after release.
            col_q        <= '0;
            row_q        <= '0;
            s1_l_q       <= '0;
            s1_r_q       <= '0;
            s1_t_q       <= '0;
            s1_b_q       <= '0;
            s1_border_q  <= 1'b0;
            s1_fdone_q   <= 1'b0;
            s1_valid_q   <= 1'b0;
            s2_gx_q      <= '0;
            s2_gy_q      <= '0;
            s2_border_q  <= 1'b0;
            s2_fdone_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            edge_q       <= '0;
            edge_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef SOBEL_THRESH_EN
            s1_thresh_q  <= THRESH_DEFAULT;
            s2_thresh_q  <= THRESH_DEFAULT;
`endif
        end else begin
            // NOTE: non-blocking, so each stage captures the previous stage's pre-edge value.
            col_q        <= col_d;
            row_q        <= row_d;
            s1_l_q       <= s1_l_d;
            s1_r_q       <= s1_r_d;
            s1_t_q       <= s1_t_d;
            s1_b_q       <= s1_b_d;
            s1_border_q  <= s1_border_d;
            s1_fdone_q   <= s1_fdone_d;
            s1_valid_q   <= s1_valid_d;
            s2_gx_q      <= s2_gx_d;
            s2_gy_q      <= s2_gy_d;
            s2_border_q  <= s2_border_d;
            s2_fdone_q   <= s2_fdone_d;
            s2_valid_q   <= s2_valid_d;
            edge_q       <= edge_d;
            edge_valid_q <= edge_valid_d;
            frame_done_q <= frame_done_d;
`ifdef SOBEL_THRESH_EN
            s1_thresh_q  <= s1_thresh_d;
            s2_thresh_q  <= s2_thresh_d;
`endif
        end
    end

    assign edge_out   = edge_q;
    assign edge_valid = edge_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_edge_detector.sv
// tb_sobel_edge_detector: directed, table-driven bench for sobel_edge_detector
// with LINE_WIDTH=8 / IMG_HEIGHT=3. Expected outputs are carried through a
// 3-deep expectation pipe and compared on every falling edge.

module tb_sobel_edge_detector;

    localparam int LW = 8;
    localparam int IH = 3;

    logic        clk;
    logic        rst;
    logic [71:0] window_in;
    logic        window_valid;
    logic        frame_start;
`ifdef SOBEL_THRESH_EN
    logic [7:0]  thr;
`endif
    logic [7:0]  edge_out;
    logic        edge_valid;
    logic        frame_done;

    sobel_edge_detector #(
        .LINE_WIDTH (LW),
        .IMG_HEIGHT (IH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .window_in    (window_in),
        .window_valid (window_valid),
        .frame_start  (frame_start),
`ifdef SOBEL_THRESH_EN
        .thresh       (thr),
`endif
        .edge_out     (edge_out),
        .edge_valid   (edge_valid),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [7:0] e;
        logic       fd;
    } exp_t;

    typedef struct {
        logic [71:0] win;
        logic [10:0] s;   // hand-computed |Gx|+|Gy|
    } vec_t;

    exp_t cur, p1, p2, p3;
    int   checks   = 0;
    int   failures = 0;
    logic chk_en   = 1'b0;
    int   m_col    = 0;
    int   m_row    = 0;
    vec_t vt[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [71:0] cols(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c);
        logic [71:0] w;
        for (int r = 0; r < 3; r++) begin
            w[24*r +: 8]      = a;
            w[24*r + 8 +: 8]  = b;
            w[24*r + 16 +: 8] = c;
        end
        return w;
    endfunction

    function automatic logic [7:0] exp_edge(input logic [10:0] s, input logic border);
        if (border) return 8'h00;
`ifdef SOBEL_THRESH_EN
        return (s >= {3'b000, thr}) ? 8'hFF : 8'h00;
`else
        return (s > 11'd255) ? 8'hFF : s[7:0];
`endif
    endfunction

    // Drive one cycle of input and record what it must produce 3 cycles later.
    task automatic send(input logic [71:0] w, input logic v, input logic fs,
                        input logic [10:0] s);
        @(posedge clk);
        #1;
        window_in    = w;
        window_valid = v;
        frame_start  = fs;
        if (fs) begin
            m_col = 0;
            m_row = 0;
        end
        cur = '0;
        cur.v = v;
        if (v) begin
            cur.e  = exp_edge(s, m_col < 2);
            cur.fd = (m_col == LW - 1) && (m_row == IH - 1);
            if (m_col == LW - 1) begin
                m_col = 0;
                m_row = (m_row == IH - 1) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send('0, 1'b0, 1'b0, 11'd0);
    endtask

    task automatic run_table();
        for (int i = 0; i < 8; i++) begin
            while (m_col < 2) send(cols(8'd0, 8'd0, 8'd255), 1'b1, 1'b0, 11'd1020);
            send(vt[i].win, 1'b1, 1'b0, vt[i].s);
        end
    endtask

    // Expectation pipe: same 3-cycle depth as the DUT, cleared by reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p1 <= '0;
            p2 <= '0;
            p3 <= '0;
        end else begin
            p1 <= cur;
            p2 <= p1;
            p3 <= p2;
        end
    end

    // Per-cycle comparison away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("edge_valid", {31'b0, edge_valid}, {31'b0, p3.v});
            check("frame_done", {31'b0, frame_done}, {31'b0, p3.fd});
            if (p3.v) check("edge_out", {24'b0, edge_out}, {24'b0, p3.e});
        end
    end

    initial begin
        logic [71:0] w;

        vt[0].win = cols(8'd100, 8'd100, 8'd100); vt[0].s = 11'd0;     // flat
        vt[1].win = cols(8'd0, 8'd0, 8'd255);     vt[1].s = 11'd1020;  // vertical step
        vt[2].win = cols(8'd255, 8'd0, 8'd0);     vt[2].s = 11'd1020;  // mirrored step
        vt[3].win = cols(8'd10, 8'd15, 8'd20);    vt[3].s = 11'd40;    // ramp
        w = cols(8'd30, 8'd30, 8'd30); w[7:0] = 8'd0;
        vt[4].win = w;                            vt[4].s = 11'd60;    // diagonal
        w = '0; w[71:64] = 8'd127;
        vt[5].win = w;                            vt[5].s = 11'd254;   // just below saturation
        w = '0; w[71:64] = 8'd128;
        vt[6].win = w;                            vt[6].s = 11'd256;   // just above saturation
        w = '0; w[55:48] = 8'd5; w[63:56] = 8'd5; w[71:64] = 8'd5;
        vt[7].win = w;                            vt[7].s = 11'd20;    // Gy only

        rst          = 1'b1;
        window_in    = '0;
        window_valid = 1'b0;
        frame_start  = 1'b0;
        cur          = '0;
`ifdef SOBEL_THRESH_EN
        thr          = 8'd64;
`endif
        repeat (3) @(posedge clk);
        #3;
        check("reset_edge_out", {24'b0, edge_out}, 32'd0);
        check("reset_edge_valid", {31'b0, edge_valid}, 32'd0);
        check("reset_frame_done", {31'b0, frame_done}, 32'd0);
`ifdef SOBEL_THRESH_EN
        check("reset_thresh_reg", {24'b0, dut.s1_thresh_q}, 32'd64);
`endif
        rst    = 1'b0;
        chk_en = 1'b1;

        // Table: first window carries frame_start, so it counts as col 0.
        send(cols(8'd0, 8'd0, 8'd255), 1'b1, 1'b1, 11'd1020);
`ifdef SOBEL_THRESH_EN
        for (int k = 0; k < 2; k++) begin
            thr = 8'(40 + k);
            run_table();
        end
`else
        run_table();
`endif
        idle(4);

        // Bubbles: valid 1,0,1 must come out as 1,0,1.
        send(cols(8'd10, 8'd15, 8'd20), 1'b1, 1'b0, 11'd40);
        send('0, 1'b0, 1'b0, 11'd0);
        send(cols(8'd255, 8'd0, 8'd0), 1'b1, 1'b0, 11'd1020);
        idle(4);

        // Mid-line frame_start coincident with a valid window restarts at col 0.
        for (int i = 0; i < 3; i++) send(cols(8'd0, 8'd0, 8'd255), 1'b1, 1'b0, 11'd1020);
        send(cols(8'd0, 8'd0, 8'd255), 1'b1, 1'b1, 11'd1020);
        for (int i = 0; i < 3; i++) send(cols(8'd0, 8'd0, 8'd255), 1'b1, 1'b0, 11'd1020);

        // Two full frames of the step: frame_start alone, then continuous wrap.
        send('0, 1'b0, 1'b1, 11'd0);
        for (int i = 0; i < 2 * LW * IH; i++)
            send(cols(8'd0, 8'd0, 8'd255), 1'b1, 1'b0, 11'd1020);
        idle(4);

        // Reset with windows in flight.
        for (int i = 0; i < 3; i++) send(cols(8'd0, 8'd0, 8'd255), 1'b1, 1'b0, 11'd1020);
        @(posedge clk);
        #1;
        window_valid = 1'b0;
        cur          = '0;
        check("pre_reset_edge_valid", {31'b0, edge_valid}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("async_reset_edge_out", {24'b0, edge_out}, 32'd0);
        check("async_reset_edge_valid", {31'b0, edge_valid}, 32'd0);
        check("async_reset_frame_done", {31'b0, frame_done}, 32'd0);
        m_col = 0;
        m_row = 0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        idle(6);
        for (int i = 0; i < 3; i++) send(cols(8'd0, 8'd0, 8'd255), 1'b1, 1'b0, 11'd1020);
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
